// File: rtl/uart_pkg.sv
// Shared types for the parameterised UART transmitter: parity mode, FSM states,
// and the parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Narrower payloads are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input parity_e mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Power-of-two FIFO with a combinational head read, used to queue words for the UART.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-buffered words sent as start, data LSB first,
// optional parity and one or two stop bits; back-to-back frames when the queue is non-empty.
module uart_tx_param import uart_pkg::*; #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_e     PARITY     = PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        transmit,
  output logic                        ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_param: illegal parameter set");
  end

  tx_state_e              r_state;
  logic                   r_tx;
  logic [CNT_W-1:0]       r_baud_cnt;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;

  logic [DATA_BITS-1:0]   w_rdata;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_bit_done;
  logic                   w_last_data;
  logic                   w_last_stop;
  logic                   w_pop;

  assign w_bit_done  = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_data = (r_bit_idx == IDX_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_idx == IDX_W'(STOP_BITS - 1));
  // Pop exactly when the FSM loads the next word into the shift register.
  assign w_pop = !w_empty &&
                 ((r_state == StIdle) || (r_state == StStop && w_bit_done && w_last_stop));

  uart_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (transmit),
    .i_wdata (data_in),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign ready = !w_full;
  assign busy  = (r_state != StIdle) || !w_empty;
  assign tx    = r_tx;

  // r_tx follows the state by one edge, so every bit spans exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
    end else begin
      if (r_state == StIdle || w_bit_done) r_baud_cnt <= '0;
      else                                 r_baud_cnt <= r_baud_cnt + CNT_W'(1);

      unique case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_state  <= StStart;
            r_shift  <= w_rdata;
            r_parity <= parity_bit(9'(w_rdata), PARITY);
          end
        end
        StStart: begin
          r_tx <= 1'b0;
          if (w_bit_done) begin
            r_state   <= StData;
            r_bit_idx <= '0;
          end
        end
        StData: begin
          r_tx <= r_shift[0];
          if (w_bit_done) begin
            r_shift <= r_shift >> 1;
            if (w_last_data) begin
              r_bit_idx <= '0;
              r_state   <= (PARITY == PARITY_NONE) ? StStop : StParity;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        StParity: begin
          r_tx <= r_parity;
          if (w_bit_done) begin
            r_state   <= StStop;
            r_bit_idx <= '0;
          end
        end
        StStop: begin
          r_tx <= 1'b1;
          if (w_bit_done) begin
            if (w_last_stop) begin
              r_bit_idx <= '0;
              if (!w_empty) begin
                r_state  <= StStart;
                r_shift  <= w_rdata;
                r_parity <= parity_bit(9'(w_rdata), PARITY);
              end else begin
                r_state <= StIdle;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four configurations share one clock; the tx line
// of the selected instance is logged every cycle and compared against frames built from data.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       tb_transmit;
  int         sel;
  logic [3:0] trans_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] ready_v;
  logic [2:0] cnt_a [4];
  logic       tx_m;
  logic       busy_m;
  logic       ready_m;
  logic [2:0] cnt_m;

  int   total;
  int   bad;
  logic txlog[$];
  int   exp_q[$];
  logic [7:0] acc[$];
  logic [7:0] w0, w1, w2;
  logic will;
  int   a, a0, dummy, r, zeros;

  always #5 clk = ~clk;

  assign trans_v = tb_transmit ? (4'b0001 << sel) : 4'b0000;
  assign tx_m    = tx_v[sel];
  assign busy_m  = busy_v[sel];
  assign ready_m = ready_v[sel];
  assign cnt_m   = cnt_a[sel];

  uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .transmit(trans_v[0]), .ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_a[0]));

  uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(PARITY_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .transmit(trans_v[1]), .ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_a[1]));

  uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(PARITY_ODD), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8o2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .transmit(trans_v[2]), .ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_a[2]));

  uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                  .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[6:0]), .transmit(trans_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_a[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    txlog.push_back(tx_m);
  endtask

  // Idle cycles with data_in scrambled, so in-flight frames must not follow it.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      data_in = 8'($urandom);
      tick();
    end
  endtask

  task automatic send(input logic [7:0] d, output int idx);
    data_in     = d;
    tb_transmit = 1'b1;
    tick();
    tb_transmit = 1'b0;
    idx = txlog.size() - 1;
  endtask

  // par: 0 none, 1 even, 2 odd
  task automatic add_frame(input int d, input int nbits, input int par, input int nstop);
    int ones = 0;
    exp_q.push_back(0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back((d >> i) & 1);
      ones += (d >> i) & 1;
    end
    if (par == 1) exp_q.push_back(ones % 2);
    else if (par == 2) exp_q.push_back(1 - ones % 2);
    for (int i = 0; i < nstop; i++) exp_q.push_back(1);
  endtask

  // One comparison per bit window: every cycle of the window must carry the expected level.
  task automatic check_span(input string tag, input int start, input int ncyc,
                            input bit idle_after);
    if (start < 1 || start + ncyc + 1 > txlog.size()) begin
      check({tag, "_log_len"}, txlog.size(), start + ncyc + 1);
      return;
    end
    check({tag, "_pre_idle"}, txlog[start-1], 1);
    for (int b = 0; b * CPB < ncyc; b++) begin
      int hits = 0;
      int len  = 0;
      for (int c = b * CPB; c < (b + 1) * CPB && c < ncyc; c++) begin
        len++;
        if (txlog[start+c] === 1'(exp_q[b])) hits++;
      end
      check($sformatf("%s_bit%0d", tag, b), hits, len);
    end
    if (idle_after) check({tag, "_post_idle"}, txlog[start+ncyc], 1);
  endtask

  task automatic one_frame(input int k, input logic [7:0] d, input int nbits, input int par,
                           input int nstop, input string tag);
    int idx;
    sel = k;
    #1;
    exp_q.delete();
    add_frame(d, nbits, par, nstop);
    send(d, idx);
    check({tag, "_busy_acc"}, busy_m, 1);
    check({tag, "_cnt_acc"}, cnt_m, 1);
    run(exp_q.size() * CPB + 3);
    check_span(tag, idx + 2, exp_q.size() * CPB, 1);
    check({tag, "_busy_end"}, busy_m, 0);
    check({tag, "_cnt_end"}, cnt_m, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; tb_transmit = 1'b0; data_in = '0; sel = 0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      check($sformatf("rst_tx%0d", k), tx_m, 1);
      check($sformatf("rst_busy%0d", k), busy_m, 0);
      check($sformatf("rst_ready%0d", k), ready_m, 1);
      check($sformatf("rst_cnt%0d", k), cnt_m, 0);
    end
    rst_n = 1'b1;
    run(3);

    one_frame(0, 8'h55, 8, 0, 1, "8n1_55");
    repeat (2) one_frame(0, 8'($urandom), 8, 0, 1, "8n1_rnd");
    one_frame(1, 8'hA3, 8, 1, 1, "8e1_a3");
    repeat (2) one_frame(1, 8'($urandom), 8, 1, 1, "8e1_rnd");
    one_frame(2, 8'hA3, 8, 2, 2, "8o2_a3");
    repeat (2) one_frame(2, 8'($urandom), 8, 2, 2, "8o2_rnd");
    one_frame(3, 8'h7F, 7, 0, 1, "7n1_7f");
    repeat (2) one_frame(3, 8'($urandom), 7, 0, 1, "7n1_rnd");

    // Hold transmit for 8 cycles into an empty depth-4 queue.
    sel = 0;
    #1;
    acc.delete();
    a0 = txlog.size();
    for (int c = 0; c < 8; c++) begin
      data_in     = 8'($urandom);
      tb_transmit = 1'b1;
      will        = ready_m;
      if (will) acc.push_back(data_in);
      tick();
    end
    tb_transmit = 1'b0;
    check("burst_accepted", acc.size(), 5);
    check("burst_ready", ready_m, 0);
    check("burst_cnt", cnt_m, 4);
    exp_q.delete();
    foreach (acc[i]) add_frame(acc[i], 8, 0, 1);
    run(exp_q.size() * CPB + 3);
    check_span("burst", a0 + 2, exp_q.size() * CPB, 1);
    check("burst_busy_end", busy_m, 0);

    // Push on the same edge the stop bit ends and pops the single queued word.
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    send(w0, a);
    send(w1, dummy);
    check("pp_cnt_a1", cnt_m, 1);
    run(99);
    check("pp_cnt_pre", cnt_m, 1);
    send(w2, dummy);
    check("pp_cnt_same", cnt_m, 1);
    exp_q.delete();
    add_frame(w0, 8, 0, 1); add_frame(w1, 8, 0, 1); add_frame(w2, 8, 0, 1);
    run(300);
    check_span("pp", a + 2, exp_q.size() * CPB, 1);

    // Reset in the middle of data bit 3 with two words still queued.
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    send(w0, a);
    send(w1, dummy);
    send(w2, dummy);
    check("rst_mid_cnt2", cnt_m, 2);
    run(42);
    exp_q.delete();
    add_frame(w0, 8, 0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_tx", tx_m, 1);
    check("rst_mid_cnt", cnt_m, 0);
    check("rst_mid_busy", busy_m, 0);
    check("rst_mid_ready", ready_m, 1);
    check_span("rst_mid_pre", a + 2, 43, 0);
    r = txlog.size() - 1;
    run(300);
    zeros = 0;
    for (int i = r; i < txlog.size(); i++) if (txlog[i] !== 1'b1) zeros++;
    check("rst_mid_no_frames", zeros, 0);
    check("rst_mid_busy_end", busy_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width; legal 5..9.
REQ-004 SHALL have parameter PARITY, default PARITY_NONE, from the package (NONE/EVEN/ODD).
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, at least 2.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-009 SHALL have port data_in, input, DATA_BITS, byte to queue.
REQ-010 SHALL have port transmit, input, 1, valid strobe for data_in.
REQ-011 SHALL have port ready, output, 1, high when FIFO not full.
REQ-012 SHALL have port tx, output, 1, serial line, idle high.
REQ-013 SHALL have port busy, output, 1, high while FSM not IDLE or FIFO non-empty.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-015 SHALL define CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division); elaboration SHALL fail if below 2 or any parameter is illegal.
REQ-016 SHALL accept a word on a rising clk edge where transmit && ready, and SHALL ignore transmit while ready is low.
REQ-017 SHALL drive ready = (fifo_count != FIFO_DEPTH), a pure function of registered occupancy.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START pops FIFO when non-empty.
REQ-019 SHALL go START->DATA->PARITY->STOP, skipping PARITY when PARITY_NONE.
REQ-020 SHALL go STOP->START directly (no idle gap) if FIFO non-empty at the end of the last stop bit, else ->IDLE.
REQ-021 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, with tx registered.
REQ-022 SHALL transmit start=0, then data LSB first, then parity, then STOP_BITS ones.
REQ-023 SHALL set even parity bit = XOR of data bits and odd parity bit = its inverse.
REQ-024 SHALL let tx fall exactly 2 clk edges after the accepting edge when idle with FIFO empty.
REQ-025 SHALL, on simultaneous push and pop, leave fifo_count unchanged with both operations taking effect; push when full never occurs (ready low).
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with no lost or duplicated words.
REQ-027 SHALL not change an in-flight frame's data when data_in changes.

Reset
REQ-028 SHALL, when rst_n is low at a clk edge, force tx=1, busy=0, ready=1, fifo_count=0, FSM=IDLE, and clear baud and bit counters.
REQ-029 SHALL, on reset mid-frame, abort the frame, discard FIFO contents, and make tx high on the edge after reset sampling.

Structure
REQ-030 SHALL put the parity_e enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD) and the tx_state_e FSM enum in package uart_pkg.
REQ-031 SHALL instantiate one sub-module, uart_fifo (parametrised width/depth, push/pop/full/empty/count), inside uart_tx_param; baud timing stays inline.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clks/bit)
REQ-032 SHALL check 8N1 with 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each 10 cycles, then idle high; busy low after 100 cycles.
REQ-033 SHALL check 8E1 with 0xA3 -> data 1,1,0,0,0,1,0,1, parity 0; and 8O2 with 0xA3 -> parity 1 then 20 cycles high.
REQ-034 SHALL hold transmit high for 8 cycles with FIFO_DEPTH=4 -> exactly 5 words accepted, ready low after the 5th, frames back-to-back with no idle gap, in order.
REQ-035 SHALL check 7N1 with 0x7F -> 9-bit frame of 90 cycles, bit 7 never sent.
REQ-036 SHALL assert rst_n=0 for 1 cycle during the DATA bit 3 of a frame with 2 words queued -> tx=1 next cycle, fifo_count=0, busy=0, and no further frames.
REQ-037 SHALL push while popping at STOP end with FIFO at 1 entry -> fifo_count stays 1 and the next frame carries the newly pushed word after the queued word.
